handover_dm: RTL and testbench

- Mobile-side decision manager; the counterpart of the base-station handover FSMs.
- Forwards per-BS signal quality (sq) to the base stations and answers the serving BS's handover request with a relative target code.
- Tracks the new BS through attach, and exposes the downlink data of the serving BS.
- Sits between the radio measurement front end and the three BS instances on the HO interface.

---
 rtl/handover_dm.sv | 264 ++++++++++++++++++++++++++
 tb/tb_handover_dm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handover_dm.sv
// handover_dm: mobile-side handover decision manager (sq forwarding, target selection, attach tracking).
// Latency: 1 cycle on sq/rx paths and all FSM outputs; no backpressure, BS handshake is level-based request/respond.
module handover_dm #(
    parameter int SQW    = 8,
    parameter int DW     = 8,
    parameter int SQ_TH  = 50,
    parameter int HYST   = 5,
    parameter int TO_CYC = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [SQW-1:0] meas_sq1,
    input  logic [SQW-1:0] meas_sq2,
    input  logic [SQW-1:0] meas_sq3,
    input  logic [2:0]     bs_dm_request,
    input  logic [2:0]     bs_dm_respond,
    input  logic [DW-1:0]  bs1_dm_data,
    input  logic [DW-1:0]  bs2_dm_data,
    input  logic [DW-1:0]  bs3_dm_data,
    input  logic [1:0]     start_bs,
    output logic [SQW-1:0] dm_bs1_sq,
    output logic [SQW-1:0] dm_bs2_sq,
    output logic [SQW-1:0] dm_bs3_sq,
    output logic [1:0]     dm_bs1_target,
    output logic [1:0]     dm_bs2_target,
    output logic [1:0]     dm_bs3_target,
    output logic [1:0]     serving,
    output logic [DW-1:0]  rx_data,
    output logic           rx_valid,
    output logic           ho_done,
    output logic           ho_fail,
    output logic [7:0]     ho_count
);

    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        DETACHED,
        ATTACH,
        CONNECTED,
        SELECT,
        ANSWER,
        WAIT_NEW
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      cand;
    logic [1:0]      new_bs;
    logic [5:0]      tgt_q;

    logic            resp_srv;
    logic            req_srv;
    logic            resp_cand;
    logic            resp_new;
    logic            expired;
    logic [1:0]      nb1;
    logic [1:0]      nb2;
    logic [SQW-1:0]  sq_srv;
    logic [SQW-1:0]  sq_c1;
    logic [SQW-1:0]  sq_c2;
    logic [SQW:0]    need;
    logic            ok1;
    logic            ok2;
    logic [1:0]      pick_code;
    logic [1:0]      pick_bs;
    logic [DW-1:0]   data_srv;

    function automatic logic bit_of(input logic [2:0] v, input logic [1:0] idx);
        case (idx)
            2'd1:    return v[0];
            2'd2:    return v[1];
            2'd3:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [SQW-1:0] sq_of(input logic [1:0] idx,
                                             input logic [SQW-1:0] a,
                                             input logic [SQW-1:0] b,
                                             input logic [SQW-1:0] c);
        case (idx)
            2'd1:    return a;
            2'd2:    return b;
            2'd3:    return c;
            default: return '0;
        endcase
    endfunction

    // Target code lands only on the port of the BS that asked for it.
    function automatic logic [5:0] place(input logic [1:0] idx, input logic [1:0] code);
        logic [5:0] r;
        r = '0;
        case (idx)
            2'd1:    r[1:0] = code;
            2'd2:    r[3:2] = code;
            2'd3:    r[5:4] = code;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        resp_srv  = bit_of(bs_dm_respond, serving);
        req_srv   = bit_of(bs_dm_request, serving);
        resp_cand = bit_of(bs_dm_respond, cand);
        resp_new  = bit_of(bs_dm_respond, new_bs);
        expired   = (cnt == CW'(TO_CYC - 1));
        nb1       = (serving == 2'd3) ? 2'd1 : serving + 2'd1;
        nb2       = (nb1 == 2'd3) ? 2'd1 : nb1 + 2'd1;
        sq_srv    = sq_of(serving, meas_sq1, meas_sq2, meas_sq3);
        sq_c1     = sq_of(nb1, meas_sq1, meas_sq2, meas_sq3);
        sq_c2     = sq_of(nb2, meas_sq1, meas_sq2, meas_sq3);
        data_srv  = '0;
        case (serving)
            2'd1:    data_srv = bs1_dm_data;
            2'd2:    data_srv = bs2_dm_data;
            2'd3:    data_srv = bs3_dm_data;
            default: data_srv = '0;
        endcase
        // One extra bit so sq_serving + HYST cannot wrap past the top of the range.
        need = {1'b0, sq_srv} + (SQW+1)'(HYST);
        ok1  = ({1'b0, sq_c1} >= (SQW+1)'(SQ_TH)) && ({1'b0, sq_c1} >= need);
        ok2  = ({1'b0, sq_c2} >= (SQW+1)'(SQ_TH)) && ({1'b0, sq_c2} >= need);
        pick_code = 2'd0;
        if (ok1 && ok2) begin
            pick_code = (sq_c2 > sq_c1) ? 2'd2 : 2'd1;
        end else if (ok1) begin
            pick_code = 2'd1;
        end else if (ok2) begin
            pick_code = 2'd2;
        end
        pick_bs = (pick_code == 2'd2) ? nb2 : nb1;
    end

    assign dm_bs1_target = tgt_q[1:0];
    assign dm_bs2_target = tgt_q[3:2];
    assign dm_bs3_target = tgt_q[5:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= DETACHED;
            cnt       <= '0;
            cand      <= 2'd0;
            new_bs    <= 2'd0;
            tgt_q     <= '0;
            dm_bs1_sq <= '0;
            dm_bs2_sq <= '0;
            dm_bs3_sq <= '0;
            serving   <= 2'd0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            ho_done   <= 1'b0;
            ho_fail   <= 1'b0;
            ho_count  <= 8'd0;
        end else begin
            dm_bs1_sq <= meas_sq1;
            dm_bs2_sq <= meas_sq2;
            dm_bs3_sq <= meas_sq3;
            ho_done   <= 1'b0;
            ho_fail   <= 1'b0;
            case (state)
                DETACHED: begin
                    serving  <= 2'd0;
                    rx_valid <= 1'b0;
                    tgt_q    <= '0;
                    if (start_bs != 2'd0) begin
                        cand  <= start_bs;
                        cnt   <= '0;
                        state <= ATTACH;
                    end
                end
                ATTACH: begin
                    rx_valid <= 1'b0;
                    if (resp_cand) begin
                        serving <= cand;
                        cnt     <= '0;
                        state   <= CONNECTED;
                    end else if (expired) begin
                        ho_fail <= 1'b1;
                        cnt     <= '0;
                        state   <= DETACHED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONNECTED: begin
                    rx_data  <= data_srv;
                    rx_valid <= resp_srv;
                    if (!resp_srv) begin
                        ho_fail <= 1'b1;
                        serving <= 2'd0;
                        cnt     <= '0;
                        state   <= DETACHED;
                    end else if (req_srv) begin
                        cnt   <= '0;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    rx_data  <= data_srv;
                    rx_valid <= resp_srv;
                    if (!resp_srv) begin
                        ho_fail <= 1'b1;
                        serving <= 2'd0;
                        cnt     <= '0;
                        state   <= DETACHED;
                    end else if (!req_srv) begin
                        cnt   <= '0;
                        state <= CONNECTED;
                    end else if (pick_code != 2'd0) begin
                        new_bs <= pick_bs;
                        tgt_q  <= place(serving, pick_code);
                        cnt    <= '0;
                        state  <= ANSWER;
                    end
                end
                ANSWER: begin
                    rx_data  <= data_srv;
                    rx_valid <= resp_srv;
                    if (!resp_srv) begin
                        cnt   <= '0;
                        state <= WAIT_NEW;
                    end else if (expired) begin
                        ho_fail  <= 1'b1;
                        serving  <= 2'd0;
                        rx_valid <= 1'b0;
                        tgt_q    <= '0;
                        cnt      <= '0;
                        state    <= DETACHED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_NEW: begin
                    rx_valid <= 1'b0;
                    if (resp_new) begin
                        serving <= new_bs;
                        tgt_q   <= '0;
                        ho_done <= 1'b1;
                        if (ho_count != 8'hFF) begin
                            ho_count <= ho_count + 8'd1;
                        end
                        cnt   <= '0;
                        state <= CONNECTED;
                    end else if (expired) begin
                        ho_fail <= 1'b1;
                        serving <= 2'd0;
                        tgt_q   <= '0;
                        cnt     <= '0;
                        state   <= DETACHED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= DETACHED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handover_dm.sv
// Directed/randomized bench for handover_dm with a rule-level target-selection model.
module tb_handover_dm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sq_in [1:3];
    logic [7:0] dat [1:3];
    logic [2:0] req;
    logic [2:0] resp;
    logic [1:0] start_bs;
    logic [7:0] dm_bs1_sq, dm_bs2_sq, dm_bs3_sq;
    logic [1:0] dm_bs1_target, dm_bs2_target, dm_bs3_target;
    logic [1:0] serving;
    logic [7:0] rx_data;
    logic       rx_valid, ho_done, ho_fail;
    logic [7:0] ho_count;

    int checks = 0;
    int failures = 0;
    int k, code, nbs;

    always #5 clk = ~clk;

    handover_dm dut (
        .clk           (clk),
        .reset         (reset),
        .meas_sq1      (sq_in[1]),
        .meas_sq2      (sq_in[2]),
        .meas_sq3      (sq_in[3]),
        .bs_dm_request (req),
        .bs_dm_respond (resp),
        .bs1_dm_data   (dat[1]),
        .bs2_dm_data   (dat[2]),
        .bs3_dm_data   (dat[3]),
        .start_bs      (start_bs),
        .dm_bs1_sq     (dm_bs1_sq),
        .dm_bs2_sq     (dm_bs2_sq),
        .dm_bs3_sq     (dm_bs3_sq),
        .dm_bs1_target (dm_bs1_target),
        .dm_bs2_target (dm_bs2_target),
        .dm_bs3_target (dm_bs3_target),
        .serving       (serving),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .ho_done       (ho_done),
        .ho_fail       (ho_fail),
        .ho_count      (ho_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // BS reached from requester serv with relative code c (c = 1 or 2).
    function automatic int other_bs(input int serv, input int c);
        return ((serv - 1 + c) % 3) + 1;
    endfunction

    // Strongest qualifying neighbour; strict '>' keeps the lower code on ties.
    function automatic int exp_code(input int serv);
        int best, best_sq, b, s;
        best = 0;
        best_sq = -1;
        for (int c = 1; c <= 2; c++) begin
            b = other_bs(serv, c);
            s = int'(sq_in[b]);
            if (s >= 50 && s >= int'(sq_in[serv]) + 5 && s > best_sq) begin
                best = c;
                best_sq = s;
            end
        end
        return best;
    endfunction

    function automatic logic [31:0] tgt_of(input int idx);
        case (idx)
            1:       return 32'(dm_bs1_target);
            2:       return 32'(dm_bs2_target);
            default: return 32'(dm_bs3_target);
        endcase
    endfunction

    initial begin
        reset    = 1'b0;
        req      = 3'b000;
        resp     = 3'b000;
        start_bs = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            sq_in[i] = 8'd0;
            dat[i]   = 8'(i);
        end
        #3;
        chk("rst_serving", 32'(serving), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_ho_count", 32'(ho_count), 0);
        chk("rst_targets", {dm_bs1_target, dm_bs2_target, dm_bs3_target}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Initial attach to BS1 after three silent cycles.
        start_bs = 2'd1;
        step();
        start_bs = 2'd0;
        step(3);
        chk("attach_wait_serving", 32'(serving), 0);
        resp[0] = 1'b1;
        dat[1]  = 8'($urandom_range(0, 255));
        step();
        chk("attach_serving", 32'(serving), 1);
        chk("attach_no_done", 32'(ho_done), 0);
        step();
        chk("attach_rx_valid", 32'(rx_valid), 1);
        chk("attach_rx_data", 32'(rx_data), 32'(dat[1]));

        // Non-serving request is ignored even with good neighbours.
        sq_in[1] = 8'd40; sq_in[2] = 8'd70; sq_in[3] = 8'd60;
        req[1] = 1'b1;
        step(3);
        chk("ignore_req_targets", {dm_bs1_target, dm_bs2_target, dm_bs3_target}, 0);
        chk("sq_path_bs2", 32'(dm_bs2_sq), 70);
        req[1] = 1'b0;

        // Handover BS1 -> BS2.
        req[0] = 1'b1;
        step(2);
        chk("ho1_target_bs1", tgt_of(1), 32'(exp_code(1)));
        chk("ho1_target_code", tgt_of(1), 1);
        resp[0] = 1'b0; req[0] = 1'b0;
        step();
        chk("ho1_wait_target_held", tgt_of(1), 1);
        chk("ho1_wait_serving_old", 32'(serving), 1);
        chk("ho1_wait_rx_valid", 32'(rx_valid), 0);
        resp[1] = 1'b1;
        step();
        chk("ho1_serving", 32'(serving), 2);
        chk("ho1_done", 32'(ho_done), 1);
        chk("ho1_count", 32'(ho_count), 1);
        chk("ho1_target_cleared", tgt_of(1), 0);
        step();
        chk("ho1_done_pulse", 32'(ho_done), 0);

        // No candidate for 10 cycles, then BS3 becomes strong.
        sq_in[1] = 8'd20; sq_in[2] = 8'd45; sq_in[3] = 8'd48;
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("nocand_targets", {dm_bs1_target, dm_bs2_target, dm_bs3_target}, 0);
        end
        sq_in[3] = 8'd80;
        step();
        chk("nocand_then_code", tgt_of(2), 32'(exp_code(2)));
        chk("nocand_then_code1", tgt_of(2), 1);
        resp[1] = 1'b0; req[1] = 1'b0;
        step();
        resp[2] = 1'b1;
        step();
        chk("ho2_serving", 32'(serving), 3);
        chk("ho2_count", 32'(ho_count), 2);

        // Tie between BS1 and BS2 from BS3: lower code wins.
        sq_in[1] = 8'd90; sq_in[2] = 8'd90; sq_in[3] = 8'd30;
        req[2] = 1'b1;
        step(2);
        chk("tie_code", tgt_of(3), 32'(exp_code(3)));
        chk("tie_code1", tgt_of(3), 1);
        resp[2] = 1'b0; req[2] = 1'b0;
        step();
        resp[0] = 1'b1;
        step();
        chk("tie_new_bs", 32'(serving), 1);
        chk("tie_count", 32'(ho_count), 3);
        chk("tie_no_fail", 32'(ho_fail), 0);

        // Random sq handover from BS1 whose new BS never answers.
        sq_in[1] = 8'($urandom_range(0, 60));
        sq_in[2] = 8'($urandom_range(0, 255));
        sq_in[3] = 8'($urandom_range(0, 255));
        if (exp_code(1) == 0) sq_in[2] = 8'd200;
        code = exp_code(1);
        req[0] = 1'b1;
        step(2);
        chk("to_code", tgt_of(1), 32'(code));
        resp[0] = 1'b0; req[0] = 1'b0;
        step();
        for (int i = 0; i < 63; i++) begin
            step();
            chk("to_early_fail", 32'(ho_fail), 0);
        end
        chk("to_target_held", tgt_of(1), 32'(code));
        chk("to_serving_held", 32'(serving), 1);
        step();
        chk("to_fail", 32'(ho_fail), 1);
        chk("to_serving", 32'(serving), 0);
        chk("to_target", {dm_bs1_target, dm_bs2_target, dm_bs3_target}, 0);
        chk("to_count_kept", 32'(ho_count), 3);

        // Random attach, random data, then link loss with simultaneous request.
        k = $urandom_range(1, 3);
        start_bs = 2'(k);
        step();
        start_bs = 2'd0;
        resp[k-1] = 1'b1;
        step();
        chk("ll_attach", 32'(serving), 32'(k));
        for (int i = 0; i < 4; i++) begin
            for (int j = 1; j <= 3; j++) dat[j] = 8'($urandom_range(0, 255));
            step();
            chk("ll_rx_data", 32'(rx_data), 32'(dat[k]));
            chk("ll_rx_valid", 32'(rx_valid), 1);
        end
        resp[k-1] = 1'b0; req[k-1] = 1'b1;
        step();
        chk("ll_fail", 32'(ho_fail), 1);
        chk("ll_no_done", 32'(ho_done), 0);
        chk("ll_serving", 32'(serving), 0);
        req[k-1] = 1'b0;
        step();
        chk("ll_fail_pulse", 32'(ho_fail), 0);
        chk("ll_rx_valid_off", 32'(rx_valid), 0);

        // Asynchronous reset while in ANSWER.
        k = $urandom_range(1, 3);
        start_bs = 2'(k);
        step();
        start_bs = 2'd0;
        resp[k-1] = 1'b1;
        step();
        for (int j = 1; j <= 3; j++) sq_in[j] = (j == k) ? 8'd10 : 8'd200;
        req[k-1] = 1'b1;
        step(2);
        chk("ar_code", tgt_of(k), 32'(exp_code(k)));
        #2 reset = 1'b0;
        #1;
        chk("ar_targets", {dm_bs1_target, dm_bs2_target, dm_bs3_target}, 0);
        chk("ar_serving", 32'(serving), 0);
        chk("ar_count", 32'(ho_count), 0);
        chk("ar_sq", {dm_bs1_sq, dm_bs2_sq, dm_bs3_sq}, 0);
        chk("ar_rx_valid", 32'(rx_valid), 0);
        step();
        reset = 1'b1;
        step();
        chk("ar_detached", 32'(serving), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
